// File: rtl/d_e_pipe_reg.sv
// rtl/d_e_pipe_reg.sv - Decode/Execute pipeline register with W-stage bypass, hold, flush and Tnew countdown
module d_e_pipe_reg #(
   parameter int DW = 32,
   parameter int AW = 5,
   parameter int TW = 2
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          en,
   input  logic          flush,
   input  logic [DW-1:0] D_PC,
   input  logic [DW-1:0] D_Instr,
   input  logic [DW-1:0] D_RD1,
   input  logic [DW-1:0] D_RD2,
   input  logic [AW-1:0] D_A1,
   input  logic [AW-1:0] D_A2,
   input  logic [AW-1:0] D_A3,
   input  logic [DW-1:0] D_Ext,
   input  logic [TW-1:0] D_Tnew,
   input  logic          D_Valid,
   input  logic          W_RegWrite,
   input  logic [AW-1:0] W_A3,
   input  logic [DW-1:0] W_WD,
   output logic [DW-1:0] E_PC,
   output logic [DW-1:0] E_Instr,
   output logic [DW-1:0] E_RD1,
   output logic [DW-1:0] E_RD2,
   output logic [DW-1:0] E_Ext,
   output logic [AW-1:0] E_A1,
   output logic [AW-1:0] E_A2,
   output logic [AW-1:0] E_A3,
   output logic [TW-1:0] E_Tnew,
   output logic          E_Valid
);

   logic          w_live;
   logic          byp1_d, byp2_d, byp1_e, byp2_e;
   logic [DW-1:0] rd1_d, rd2_d;
   logic [TW-1:0] tnew_d;

   // Register 0 is hardwired, so a write to it must never be forwarded.
   assign w_live = W_RegWrite && (W_A3 != '0);
   assign byp1_d = w_live && (W_A3 == D_A1);
   assign byp2_d = w_live && (W_A3 == D_A2);
   assign byp1_e = w_live && (W_A3 == E_A1);
   assign byp2_e = w_live && (W_A3 == E_A2);

   assign rd1_d  = byp1_d ? W_WD : D_RD1;
   assign rd2_d  = byp2_d ? W_WD : D_RD2;
   assign tnew_d = (D_Tnew == '0) ? '0 : D_Tnew - TW'(1);

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         E_PC    <= '0;
         E_Instr <= '0;
         E_RD1   <= '0;
         E_RD2   <= '0;
         E_Ext   <= '0;
         E_A1    <= '0;
         E_A2    <= '0;
         E_A3    <= '0;
         E_Tnew  <= '0;
         E_Valid <= 1'b0;
      end else if (flush) begin
         // Bubble keeps the PC so exception/return logic still sees the macro PC.
         E_PC    <= D_PC;
         E_Instr <= '0;
         E_RD1   <= '0;
         E_RD2   <= '0;
         E_Ext   <= '0;
         E_A1    <= '0;
         E_A2    <= '0;
         E_A3    <= '0;
         E_Tnew  <= '0;
         E_Valid <= 1'b0;
      end else if (en) begin
         E_PC    <= D_PC;
         E_Instr <= D_Instr;
         E_RD1   <= rd1_d;
         E_RD2   <= rd2_d;
         E_Ext   <= D_Ext;
         E_A1    <= D_A1;
         E_A2    <= D_A2;
         E_A3    <= D_A3;
         E_Tnew  <= tnew_d;
         E_Valid <= D_Valid;
      end else begin
         // Held operands pick up register-file writes that land during the stall.
         if (byp1_e) E_RD1 <= W_WD;
         if (byp2_e) E_RD2 <= W_WD;
      end
   end

endmodule

// File: tb/tb_d_e_pipe_reg.sv
// tb/tb_d_e_pipe_reg.sv - Scoreboard bench for d_e_pipe_reg
module tb_d_e_pipe_reg;

   logic        clk = 1'b0;
   logic        reset, en, flush;
   logic [31:0] D_PC, D_Instr, D_RD1, D_RD2, D_Ext;
   logic [4:0]  D_A1, D_A2, D_A3;
   logic [1:0]  D_Tnew;
   logic        D_Valid;
   logic        W_RegWrite;
   logic [4:0]  W_A3;
   logic [31:0] W_WD;
   logic [31:0] E_PC, E_Instr, E_RD1, E_RD2, E_Ext;
   logic [4:0]  E_A1, E_A2, E_A3;
   logic [1:0]  E_Tnew;
   logic        E_Valid;

   typedef struct {
      logic [31:0] pc, instr, rd1, rd2, ext;
      logic [4:0]  a1, a2, a3;
      logic [1:0]  tnew;
      logic        valid;
   } exp_t;

   exp_t cur;
   exp_t sb[$];
   int   n_cmp = 0;
   int   n_bad = 0;
   bit   done  = 0;

   d_e_pipe_reg dut (
      .clk(clk), .reset(reset), .en(en), .flush(flush),
      .D_PC(D_PC), .D_Instr(D_Instr), .D_RD1(D_RD1), .D_RD2(D_RD2),
      .D_A1(D_A1), .D_A2(D_A2), .D_A3(D_A3), .D_Ext(D_Ext),
      .D_Tnew(D_Tnew), .D_Valid(D_Valid),
      .W_RegWrite(W_RegWrite), .W_A3(W_A3), .W_WD(W_WD),
      .E_PC(E_PC), .E_Instr(E_Instr), .E_RD1(E_RD1), .E_RD2(E_RD2), .E_Ext(E_Ext),
      .E_A1(E_A1), .E_A2(E_A2), .E_A3(E_A3), .E_Tnew(E_Tnew), .E_Valid(E_Valid)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic chk_zero(input string tag);
      chk({tag, ".E_PC"},    E_PC, 0);
      chk({tag, ".E_Instr"}, E_Instr, 0);
      chk({tag, ".E_RD1"},   E_RD1, 0);
      chk({tag, ".E_RD2"},   E_RD2, 0);
      chk({tag, ".E_Ext"},   E_Ext, 0);
      chk({tag, ".E_A1"},    32'(E_A1), 0);
      chk({tag, ".E_A2"},    32'(E_A2), 0);
      chk({tag, ".E_A3"},    32'(E_A3), 0);
      chk({tag, ".E_Tnew"},  32'(E_Tnew), 0);
      chk({tag, ".E_Valid"}, 32'(E_Valid), 0);
   endtask

   // Monitor: one expected snapshot per clock edge once stimulus has queued one.
   initial begin
      exp_t e;
      forever begin
         @(posedge clk);
         #1;
         if (sb.size() > 0) begin
            e = sb.pop_front();
            chk("E_PC",    E_PC, e.pc);
            chk("E_Instr", E_Instr, e.instr);
            chk("E_RD1",   E_RD1, e.rd1);
            chk("E_RD2",   E_RD2, e.rd2);
            chk("E_Ext",   E_Ext, e.ext);
            chk("E_A1",    32'(E_A1), 32'(e.a1));
            chk("E_A2",    32'(E_A2), 32'(e.a2));
            chk("E_A3",    32'(E_A3), 32'(e.a3));
            chk("E_Tnew",  32'(E_Tnew), 32'(e.tnew));
            chk("E_Valid", 32'(E_Valid), 32'(e.valid));
         end
      end
   end

   task automatic setd(input logic [31:0] pc, instr, rd1, rd2,
                       input logic [4:0] a1, a2, a3,
                       input logic [31:0] ext, input logic [1:0] tnew, input logic valid);
      D_PC = pc; D_Instr = instr; D_RD1 = rd1; D_RD2 = rd2;
      D_A1 = a1; D_A2 = a2; D_A3 = a3; D_Ext = ext; D_Tnew = tnew; D_Valid = valid;
   endtask

   task automatic setw(input logic we, input logic [4:0] a3, input logic [31:0] wd);
      W_RegWrite = we; W_A3 = a3; W_WD = wd;
   endtask

   // Capture expectation: fields mirror the stimulus just applied, rd/tnew given by hand.
   task automatic exp_cap(input logic [31:0] rd1, rd2, input logic [1:0] tnew);
      cur.pc = D_PC; cur.instr = D_Instr; cur.ext = D_Ext;
      cur.a1 = D_A1; cur.a2 = D_A2; cur.a3 = D_A3; cur.valid = D_Valid;
      cur.rd1 = rd1; cur.rd2 = rd2; cur.tnew = tnew;
   endtask

   task automatic exp_bubble(input logic [31:0] pc);
      cur.instr = 0; cur.rd1 = 0; cur.rd2 = 0; cur.ext = 0;
      cur.a1 = 0; cur.a2 = 0; cur.a3 = 0; cur.tnew = 0; cur.valid = 0;
      cur.pc = pc;
   endtask

   task automatic step(input logic f, input logic e);
      flush = f; en = e;
      sb.push_back(cur);
      @(negedge clk);
   endtask

   initial begin
      reset = 1'b0; en = 1'b1; flush = 1'b0;
      setd(32'h1000, 32'h8C220004, 32'h11, 32'h22, 5'd1, 5'd2, 5'd3, 32'h4, 2'd2, 1'b1);
      setw(1'b1, 5'd4, 32'hDEAD);
      repeat (2) @(negedge clk);
      chk_zero("rst_init");
      reset = 1'b1;

      // First capture after reset release
      exp_cap(32'h11, 32'h22, 2'd1);
      step(1'b0, 1'b1);

      // Asynchronous reset between edges with non-zero inputs
      #2 reset = 1'b0;
      #1 chk_zero("rst_async");
      @(posedge clk); #1 chk_zero("rst_held");
      @(negedge clk); reset = 1'b1;

      // Capture bypass on port 1; port 2 untouched
      setd(32'h2000, 32'h01234567, 32'h1111, 32'h2222, 5'd5, 5'd6, 5'd8, 32'hFFFF_FFF0, 2'd3, 1'b1);
      setw(1'b1, 5'd5, 32'hABCD);
      exp_cap(32'hABCD, 32'h2222, 2'd2);
      step(1'b0, 1'b1);

      // Register 0 is never bypassed
      setd(32'h2004, 32'h00000000, 32'h1111, 32'h2222, 5'd0, 5'd0, 5'd0, 32'h0, 2'd1, 1'b1);
      setw(1'b1, 5'd0, 32'hABCD);
      exp_cap(32'h1111, 32'h2222, 2'd0);
      step(1'b0, 1'b1);

      // Dual bypass
      setd(32'h2008, 32'h00E73820, 32'h100, 32'h200, 5'd7, 5'd7, 5'd9, 32'h7, 2'd0, 1'b1);
      setw(1'b1, 5'd7, 32'h55);
      exp_cap(32'h55, 32'h55, 2'd0);
      step(1'b0, 1'b1);

      // Same addresses, no write -> raw operands
      setd(32'h200C, 32'h00E73820, 32'h100, 32'h200, 5'd7, 5'd7, 5'd9, 32'h7, 2'd2, 1'b0);
      setw(1'b0, 5'd7, 32'h55);
      exp_cap(32'h100, 32'h200, 2'd1);
      step(1'b0, 1'b1);

      // Hold refresh: capture E_A1=8, E_A2=9
      setd(32'h2010, 32'h01095020, 32'h30, 32'h10, 5'd8, 5'd9, 5'd10, 32'h1, 2'd3, 1'b1);
      setw(1'b0, 5'd0, 32'h0);
      exp_cap(32'h30, 32'h10, 2'd2);
      step(1'b0, 1'b1);
      // Hold 1: D inputs change and W hits the new D_A1, not E_A1 -> nothing moves
      setd(32'h9999, 32'hFFFFFFFF, 32'hEEEE, 32'hDDDD, 5'd5, 5'd6, 5'd1, 32'h2, 2'd3, 1'b0);
      setw(1'b1, 5'd5, 32'h77);
      step(1'b0, 1'b0);
      // Hold 2: W writes $9 -> E_RD2 refreshed
      setw(1'b1, 5'd9, 32'h20);
      cur.rd2 = 32'h20;
      step(1'b0, 1'b0);
      // Hold 3: no write -> stays
      setw(1'b0, 5'd9, 32'h99);
      step(1'b0, 1'b0);

      // Flush with en=0; X on dropped inputs must not leak
      setd(32'h3004, 32'hx, 32'hx, 32'hx, 5'd31, 5'd31, 5'd31, 32'hx, 2'd3, 1'b1);
      setw(1'b1, 5'd31, 32'h1234);
      exp_bubble(32'h3004);
      step(1'b1, 1'b0);

      // Flush also overrides en=1
      setd(32'h3008, 32'hAAAA5555, 32'h1, 32'h2, 5'd3, 5'd4, 5'd12, 32'h9, 2'd2, 1'b1);
      setw(1'b0, 5'd0, 32'h0);
      exp_bubble(32'h3008);
      step(1'b1, 1'b1);

      // Hold on a bubble: write to $0 must not alter the zero operands
      setw(1'b1, 5'd0, 32'hBEEF);
      step(1'b0, 1'b0);

      // Reset asserted mid-flush dominates
      flush = 1'b1; en = 1'b1;
      #2 reset = 1'b0;
      #1 chk_zero("rst_flush");
      @(posedge clk); #1 chk_zero("rst_flush_held");
      @(negedge clk); reset = 1'b1;

      // Tnew=1 -> 0, after reset
      setd(32'h4000, 32'h12345678, 32'hCAFE, 32'hF00D, 5'd11, 5'd12, 5'd13, 32'h5, 2'd1, 1'b1);
      setw(1'b0, 5'd11, 32'h0);
      exp_cap(32'hCAFE, 32'hF00D, 2'd0);
      step(1'b0, 1'b1);

      for (int i = 0; i < 10 && sb.size() > 0; i++) @(negedge clk);
      if (sb.size() != 0) begin
         n_cmp++; n_bad++;
         $display("FAIL drain: %0d expectations left, required 0", sb.size());
      end
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
